writeback_unit: RTL and testbench

- Final pipeline stage. Accepts completed instructions from the memory stage, waits for load data where needed, then aligns and extends it.
- Drives the register-file write port (o_wback/o_wreg/o_wdata) that the register read stage consumes.
- Maintains the retired-instruction counter and flags load faults.

---
 rtl/writeback_unit.sv | 182 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit -- final pipeline stage.
//
// Takes completed instructions from the memory stage. ALU and link results
// retire the cycle after they are accepted. Loads wait for memory data, which
// is then aligned and sign/zero-extended. The unit also keeps the retired-
// instruction counter and raises a fault pulse for illegal loads and for load
// timeouts.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_valid/o_ready accept handshake from the memory stage (o_ready = IDLE)
//   i_kind          0 none, 1 ALU result, 2 load, 3 link (pc+4)
//   i_rd            destination register
//   i_result, i_pc  ALU result / instruction PC
//   i_funct3        load width (LB/LH/LW/LBU/LHU)
//   i_addr_lo       load address bits [1:0]
//   i_mem_rvalid    load data valid; i_mem_rdata is the aligned word
//   o_wback/o_wreg/o_wdata  register-file write port (registered)
//   o_retire        one pulse per retired instruction
//   o_fault         one pulse per illegal load or load timeout
//   o_instret       retired-instruction count (wraps)
module writeback_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_kind,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_result,
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wback,
    output logic [4:0]  o_wreg,
    output logic [31:0] o_wdata,
    output logic        o_retire,
    output logic        o_fault,
    output logic [31:0] o_instret
);

    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    // The counter only has to hold 0..TIMEOUT-1: the timeout fires on the
    // cycle it would step to TIMEOUT.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    rd_q, rd_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    alo_q, alo_d;
    logic          wback_q, wback_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          retire_q, retire_d;
    logic          fault_q, fault_d;
    logic [31:0]   instret_q, instret_d;

    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] alo);
        case (f3)
            3'd0, 3'd4: load_legal = 1'b1;
            3'd1, 3'd5: load_legal = ~alo[0];
            3'd2:       load_legal = (alo == 2'd0);
            default:    load_legal = 1'b0;
        endcase
    endfunction

    // Load alignment/extension uses the captured width and offset.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = i_mem_rdata[{alo_q, 3'b000} +: 8];
        ld_half = i_mem_rdata[{alo_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_ext = {24'd0, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_ext = {16'd0, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        f3_d      = f3_q;
        alo_d     = alo_q;
        wback_d   = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        retire_d  = 1'b0;
        fault_d   = 1'b0;
        instret_d = instret_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (i_kind == 2'd2) begin
                        if (load_legal(i_funct3, i_addr_lo)) begin
                            rd_d    = i_rd;
                            f3_d    = i_funct3;
                            alo_d   = i_addr_lo;
                            cnt_d   = '0;
                            state_d = S_WAIT_MEM;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end else begin
                        retire_d = 1'b1;
                        wback_d  = (i_kind != 2'd0) && (i_rd != 5'd0);
                        wreg_d   = i_rd;
                        if (i_kind == 2'd1) wdata_d = i_result;
                        if (i_kind == 2'd3) wdata_d = i_pc + 32'd4;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (i_mem_rvalid) begin
                    retire_d = 1'b1;
                    wback_d  = (rd_q != 5'd0);
                    wreg_d   = rd_q;
                    wdata_d  = ld_ext;
                    state_d  = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter advances together with the retire pulse it counts.
        if (retire_d) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            f3_q      <= '0;
            alo_q     <= '0;
            wback_q   <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            f3_q      <= f3_d;
            alo_q     <= alo_d;
            wback_q   <= wback_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            retire_q  <= retire_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_wback   = wback_q;
    assign o_wreg    = wreg_q;
    assign o_wdata   = wdata_q;
    assign o_retire  = retire_q;
    assign o_fault   = fault_q;
    assign o_instret = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_kind;
    logic [4:0]  i_rd;
    logic [31:0] i_result;
    logic [31:0] i_pc;
    logic [2:0]  i_funct3;
    logic [1:0]  i_addr_lo;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_wback;
    logic [4:0]  o_wreg;
    logic [31:0] o_wdata;
    logic        o_retire;
    logic        o_fault;
    logic [31:0] o_instret;

    writeback_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_kind(i_kind), .i_rd(i_rd), .i_result(i_result), .i_pc(i_pc),
        .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_wback(o_wback), .o_wreg(o_wreg), .o_wdata(o_wdata),
        .o_retire(o_retire), .o_fault(o_fault), .o_instret(o_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        wb;
        logic        ret;
        logic        flt;
        logic [4:0]  rg;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input string nm, input logic wb, input logic ret,
                             input logic flt, input logic [4:0] rg, input logic [31:0] dat);
        exp_t e;
        e.nm = nm; e.wb = wb; e.ret = ret; e.flt = flt; e.rg = rg; e.dat = dat;
        sb.push_back(e);
        if (ret) exp_instret = exp_instret + 32'd1;
    endtask

    // Scoreboard monitor: any output event pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (o_wback || o_retire || o_fault)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: wback=%0b retire=%0b fault=%0b wreg=%0d wdata=0x%08h, none expected",
                         o_wback, o_retire, o_fault, o_wreg, o_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, ".wback"},  32'(o_wback),  32'(e.wb));
                chk({e.nm, ".retire"}, 32'(o_retire), 32'(e.ret));
                chk({e.nm, ".fault"},  32'(o_fault),  32'(e.flt));
                if (e.wb) begin
                    chk({e.nm, ".wreg"},  32'(o_wreg), 32'(e.rg));
                    chk({e.nm, ".wdata"}, o_wdata,     e.dat);
                end
            end
        end
    end

    // All driving tasks start and end at posedge + 1.
    task automatic issue(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] alo);
        i_valid = 1'b1; i_kind = k; i_rd = rd; i_result = res; i_pc = pc;
        i_funct3 = f3; i_addr_lo = alo;
        @(posedge clk); #1;
        i_valid = 1'b0; i_kind = 2'd0;
    endtask

    task automatic mem(input logic [31:0] d);
        i_mem_rvalid = 1'b1; i_mem_rdata = d;
        @(posedge clk); #1;
        i_mem_rvalid = 1'b0;
    endtask

    task automatic tick_ready(input logic exp);
        @(negedge clk);
        chk("ready", 32'(o_ready), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_kind = 0; i_rd = 0; i_result = 0; i_pc = 0;
        i_funct3 = 0; i_addr_lo = 0; i_mem_rvalid = 1'b0; i_mem_rdata = 0;

        // reset values
        @(posedge clk);
        @(negedge clk);
        chk("rst.ready",   32'(o_ready),  32'd1);
        chk("rst.wback",   32'(o_wback),  32'd0);
        chk("rst.retire",  32'(o_retire), 32'd0);
        chk("rst.fault",   32'(o_fault),  32'd0);
        chk("rst.wreg",    32'(o_wreg),   32'd0);
        chk("rst.wdata",   o_wdata,       32'd0);
        chk("rst.instret", o_instret,     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // back-to-back ALU then link
        expect_ev("alu", 1, 1, 0, 5'd5, 32'hDEADBEEF);
        expect_ev("link", 1, 1, 0, 5'd1, 32'h00000104);
        issue(2'd1, 5'd5, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0);
        issue(2'd3, 5'd1, 32'h0, 32'h00000100, 3'd0, 2'd0);
        tick_ready(1'b1);
        idle(1);
        chk("instret.b2b", o_instret, 32'd2);

        // LB, data 3 cycles after accept
        expect_ev("lb", 1, 1, 0, 5'd6, 32'hFFFFFF80);
        issue(2'd2, 5'd6, 0, 0, 3'd0, 2'd3);
        tick_ready(1'b0);
        tick_ready(1'b0);
        mem(32'h80112233);
        tick_ready(1'b1);

        // LBU same inputs
        expect_ev("lbu", 1, 1, 0, 5'd6, 32'h00000080);
        issue(2'd2, 5'd6, 0, 0, 3'd4, 2'd3);
        tick_ready(1'b0);
        tick_ready(1'b0);
        mem(32'h80112233);
        idle(1);

        // LB lane 1, earliest data
        expect_ev("lb1", 1, 1, 0, 5'd8, 32'h00000022);
        issue(2'd2, 5'd8, 0, 0, 3'd0, 2'd1);
        mem(32'h80112233);
        idle(1);

        // LH upper half, LHU lower half, LW
        expect_ev("lh", 1, 1, 0, 5'd10, 32'hFFFF8001);
        issue(2'd2, 5'd10, 0, 0, 3'd1, 2'd2);
        mem(32'h8001ABCD);
        expect_ev("lhu", 1, 1, 0, 5'd11, 32'h0000ABCD);
        issue(2'd2, 5'd11, 0, 0, 3'd5, 2'd0);
        mem(32'h8001ABCD);
        expect_ev("lw", 1, 1, 0, 5'd12, 32'h12345678);
        issue(2'd2, 5'd12, 0, 0, 3'd2, 2'd0);
        mem(32'h12345678);
        idle(2);
        chk("instret.loads", o_instret, exp_instret);

        // illegal loads: misaligned LH, funct3=3, misaligned LW
        expect_ev("lh_mis", 0, 0, 1, 5'd0, 32'd0);
        issue(2'd2, 5'd13, 0, 0, 3'd1, 2'd1);
        tick_ready(1'b1);
        expect_ev("f3_bad", 0, 0, 1, 5'd0, 32'd0);
        issue(2'd2, 5'd13, 0, 0, 3'd3, 2'd0);
        expect_ev("lw_mis", 0, 0, 1, 5'd0, 32'd0);
        issue(2'd2, 5'd13, 0, 0, 3'd2, 2'd2);
        idle(2);
        chk("instret.fault", o_instret, exp_instret);

        // timeout after 4 waiting cycles, then stray rvalid in IDLE
        expect_ev("timeout", 0, 0, 1, 5'd0, 32'd0);
        issue(2'd2, 5'd9, 0, 0, 3'd2, 2'd0);
        repeat (4) tick_ready(1'b0);
        tick_ready(1'b1);
        mem(32'hFFFFFFFF);
        idle(2);

        // rvalid during an ALU accept is ignored
        expect_ev("alu_rv", 1, 1, 0, 5'd3, 32'h00000055);
        i_mem_rvalid = 1'b1;
        issue(2'd1, 5'd3, 32'h55, 0, 3'd0, 2'd0);
        i_mem_rvalid = 1'b0;

        // rd=0 retires without wback, kind 0 retires only
        expect_ev("rd0", 0, 1, 0, 5'd0, 32'd0);
        issue(2'd1, 5'd0, 32'h1234, 0, 3'd0, 2'd0);
        expect_ev("kind0", 0, 1, 0, 5'd4, 32'd0);
        issue(2'd0, 5'd4, 32'h0, 0, 3'd0, 2'd0);
        idle(2);
        chk("instret.misc", o_instret, exp_instret);

        // counter wrap
        @(negedge clk);
        force dut.instret_q = 32'hFFFFFFFE;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFFFFFE;
        @(posedge clk); #1;
        expect_ev("wrap1", 1, 1, 0, 5'd2, 32'h1);
        issue(2'd1, 5'd2, 32'h1, 0, 3'd0, 2'd0);
        idle(1);
        chk("instret.max", o_instret, exp_instret);
        expect_ev("wrap2", 1, 1, 0, 5'd2, 32'h2);
        issue(2'd1, 5'd2, 32'h2, 0, 3'd0, 2'd0);
        idle(1);
        chk("instret.wrap", o_instret, exp_instret);

        // reset during WAIT_MEM abandons the load
        issue(2'd2, 5'd3, 0, 0, 3'd2, 2'd0);
        idle(1);
        rst = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_instret = 32'd0;
        @(negedge clk);
        chk("rstw.ready",   32'(o_ready),  32'd1);
        chk("rstw.wback",   32'(o_wback),  32'd0);
        chk("rstw.retire",  32'(o_retire), 32'd0);
        chk("rstw.fault",   32'(o_fault),  32'd0);
        chk("rstw.wreg",    32'(o_wreg),   32'd0);
        chk("rstw.wdata",   o_wdata,       32'd0);
        chk("rstw.instret", o_instret,     32'd0);
        @(posedge clk); #1;
        i_mem_rvalid = 1'b0;
        idle(3);
        chk("rstw.instret_after", o_instret, exp_instret);
        chk("rstw.wdata_after",   o_wdata,   32'd0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
